// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: 3-digit packed-BCD counter sequencer with prescaled RUN ticks,
// start/stop/clear/step commands and a terminal count that wraps or halts.
module bcd_count_ctrl #(
    parameter int          TICK_DIV = 100_000,
    parameter logic [11:0] LIMIT    = 12'h999,
    parameter bit          WRAP     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        step,
    output logic [11:0] count,
    output logic        running,
    output logic        done,
    output logic        wrap_pulse
);
    localparam int PW = $clog2(TICK_DIV);
    // Encoded so running/done come straight from state flops.
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
    state_t         state_q;
    logic [PW-1:0]  presc_q;
    logic [11:0]    count_q, count_d;
    logic           wrap_q, c0, c1, tick, inc;
    always_comb begin
        c0 = count_q[3:0] == 4'd9;
        c1 = c0 && count_q[7:4] == 4'd9;
        count_d = {c1 ? (count_q[11:8] == 4'd9 ? 4'd0 : count_q[11:8] + 4'd1) : count_q[11:8],
                   c0 ? (count_q[7:4] == 4'd9 ? 4'd0 : count_q[7:4] + 4'd1) : count_q[7:4],
                   c0 ? 4'd0 : count_q[3:0] + 4'd1};
        tick = state_q == RUN && presc_q == PW'(TICK_DIV - 1);
        inc = (state_q == RUN && !stop && tick) || (state_q == IDLE && step && !start && !stop);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (clear) begin
                state_q <= IDLE;
                presc_q <= '0;
                count_q <= '0;
            end else begin
                if (state_q == IDLE && start && !stop) state_q <= IDLE == IDLE ? RUN : IDLE;
                if (state_q == RUN && stop) state_q <= IDLE;
                presc_q <= (state_q == RUN && !stop && !tick) ? presc_q + 1'b1 : '0;
                if (inc) begin
                    if (count_q == LIMIT) begin
                        if (WRAP) begin
                            count_q <= '0;
                            wrap_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                        end
                    end else begin
                        count_q <= count_d;
                    end
                end
            end
        end
    end
    assign count      = count_q;
    assign running    = state_q[0];
    assign done       = state_q[1];
    assign wrap_pulse = wrap_q;
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: directed vector table plus hand sequences for two
// configurations: wrapping at 999 and halting at 025, both with TICK_DIV=4.
module tb_bcd_count_ctrl;
    localparam logic [4:0] NON = 5'b00000, STE = 5'b00001, STA = 5'b00010,
                           STP = 5'b00100, CLR = 5'b01000, RST = 5'b10000;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic a_rst = 0, a_start = 0, a_stop = 0, a_clear = 0, a_step = 0;
    logic b_rst = 0, b_start = 0, b_stop = 0, b_clear = 0, b_step = 0;
    logic [11:0] a_count, b_count;
    logic a_running, a_done, a_wrap, b_running, b_done, b_wrap;
    int checks = 0, errors = 0;

    bcd_count_ctrl #(.TICK_DIV(4), .LIMIT(12'h999), .WRAP(1'b1)) dut_a (
        .clk(clk), .reset(a_rst), .start(a_start), .stop(a_stop), .clear(a_clear), .step(a_step),
        .count(a_count), .running(a_running), .done(a_done), .wrap_pulse(a_wrap));
    bcd_count_ctrl #(.TICK_DIV(4), .LIMIT(12'h025), .WRAP(1'b0)) dut_b (
        .clk(clk), .reset(b_rst), .start(b_start), .stop(b_stop), .clear(b_clear), .step(b_step),
        .count(b_count), .running(b_running), .done(b_done), .wrap_pulse(b_wrap));

    typedef struct {
        logic [4:0]  cmd;
        logic [11:0] cnt;
        logic        run, dn, wp;
    } vec_t;
    vec_t vecs[25];

    function automatic vec_t mk(input logic [4:0] c, input logic [11:0] n, input logic r, d, w);
        vec_t v;
        v.cmd = c; v.cnt = n; v.run = r; v.dn = d; v.wp = w;
        return v;
    endfunction

    function automatic logic [11:0] bcd(input int n);
        return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic cyc(input logic [4:0] ca, input logic [4:0] cb);
        {a_rst, a_clear, a_stop, a_start, a_step} = ca;
        {b_rst, b_clear, b_stop, b_start, b_step} = cb;
        @(posedge clk);
        #1;
        {a_rst, a_clear, a_stop, a_start, a_step} = '0;
        {b_rst, b_clear, b_stop, b_start, b_step} = '0;
    endtask

    task automatic chk(input string nm, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got count=%h run=%b done=%b wrap=%b, want count=%h run=%b done=%b wrap=%b",
                     nm, got[14:3], got[2], got[1], got[0], exp[14:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [14:0] oa();
        return {a_count, a_running, a_done, a_wrap};
    endfunction

    function automatic logic [14:0] ob();
        return {b_count, b_running, b_done, b_wrap};
    endfunction

    initial begin
        vecs[0]  = mk(RST,       12'h000, 0, 0, 0);
        vecs[1]  = mk(NON,       12'h000, 0, 0, 0);
        vecs[2]  = mk(STE,       12'h001, 0, 0, 0);
        vecs[3]  = mk(STE,       12'h002, 0, 0, 0);
        vecs[4]  = mk(STA | STE, 12'h002, 1, 0, 0);
        vecs[5]  = mk(NON,       12'h002, 1, 0, 0);
        vecs[6]  = mk(STE,       12'h002, 1, 0, 0);
        vecs[7]  = mk(NON,       12'h002, 1, 0, 0);
        vecs[8]  = mk(NON,       12'h003, 1, 0, 0);
        vecs[9]  = mk(STA,       12'h003, 1, 0, 0);
        vecs[10] = mk(NON,       12'h003, 1, 0, 0);
        vecs[11] = mk(NON,       12'h003, 1, 0, 0);
        vecs[12] = mk(NON,       12'h004, 1, 0, 0);
        vecs[13] = mk(NON,       12'h004, 1, 0, 0);
        vecs[14] = mk(NON,       12'h004, 1, 0, 0);
        vecs[15] = mk(STP,       12'h004, 0, 0, 0);
        vecs[16] = mk(STA,       12'h004, 1, 0, 0);
        vecs[17] = mk(NON,       12'h004, 1, 0, 0);
        vecs[18] = mk(NON,       12'h004, 1, 0, 0);
        vecs[19] = mk(NON,       12'h004, 1, 0, 0);
        vecs[20] = mk(NON,       12'h005, 1, 0, 0);
        vecs[21] = mk(STA | STP, 12'h005, 0, 0, 0);
        vecs[22] = mk(STA | STP, 12'h005, 0, 0, 0);
        vecs[23] = mk(CLR | STA, 12'h000, 0, 0, 0);
        vecs[24] = mk(STE,       12'h001, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 25; i++) begin
            cyc(vecs[i].cmd, i == 0 ? RST : NON);
            chk($sformatf("vec%0d", i), oa(), {vecs[i].cnt, vecs[i].run, vecs[i].dn, vecs[i].wp});
        end
        // first tick latency and decimal carries up to 100
        cyc(RST, NON);
        chk("reset_a", oa(), {12'h000, 3'b000});
        for (int k = 0; k <= 400; k++) begin
            cyc(k == 0 ? STA : NON, NON);
            chk($sformatf("run_k%0d", k), oa(), {bcd(k / 4), 3'b100});
        end
        cyc(STP, NON);
        chk("stop_at_100", oa(), {12'h100, 3'b000});
        for (int i = 0; i < 898; i++) cyc(STE, NON);
        chk("step_to_998", oa(), {12'h998, 3'b000});
        for (int k = 0; k <= 9; k++) begin
            cyc(k == 0 ? STA : NON, NON);
            chk($sformatf("wrap_k%0d", k), oa(),
                {k < 4 ? 12'h998 : k < 8 ? 12'h999 : 12'h000, 1'b1, 1'b0, k == 8});
        end
        // reset in the middle of RUN
        cyc(STP | CLR, NON);
        for (int i = 0; i < 357; i++) cyc(STE, NON);
        chk("step_to_357", oa(), {12'h357, 3'b000});
        cyc(STA, NON);
        cyc(NON, NON);
        cyc(NON, NON);
        chk("run_357", oa(), {12'h357, 3'b100});
        cyc(RST, NON);
        chk("reset_mid_run", oa(), {12'h000, 3'b000});
        // halting configuration
        for (int k = 0; k <= 104; k++) begin
            cyc(NON, k == 0 ? STA : NON);
            chk($sformatf("halt_k%0d", k), ob(), k < 104 ? {bcd(k / 4), 3'b100} : {12'h025, 3'b010});
        end
        cyc(NON, STA);
        chk("done_start", ob(), {12'h025, 3'b010});
        cyc(NON, STE);
        chk("done_step", ob(), {12'h025, 3'b010});
        cyc(NON, STP);
        chk("done_stop", ob(), {12'h025, 3'b010});
        cyc(NON, CLR);
        chk("done_clear", ob(), {12'h000, 3'b000});
        for (int i = 0; i < 25; i++) cyc(NON, STE);
        chk("b_step_025", ob(), {12'h025, 3'b000});
        cyc(NON, STE);
        chk("b_step_done", ob(), {12'h025, 3'b010});
        cyc(NON, RST);
        chk("b_reset", ob(), {12'h000, 3'b000});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Sequencer for a 3-digit packed-BCD count register, suitable as a stopwatch or event counter.
- Derives an increment strobe from a programmable prescaler.
- Applies decimal increments (digits 0-9) under start/stop/clear/step commands.
- Enforces a terminal count, either wrapping or halting.
- Sits between board push-button/debounce logic and the seven-segment display driver; its count output feeds the display directly.

Parameters:
TICK_DIV, 100_000, clock cycles per increment in RUN (1 ms at 100 MHz); minimum 2.
LIMIT, 12'h999, terminal count in packed BCD; every nibble must be 0-9.
WRAP, 1, 1 = wrap to 000 after LIMIT and continue; 0 = halt in DONE at LIMIT.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle command: begin/resume counting
stop  in  1  single-cycle command: pause counting
clear  in  1  single-cycle command: zero count, return to IDLE
step  in  1  single-cycle command: one manual increment (IDLE only)
count  out  12  packed BCD count {hundreds, tens, ones}
running  out  1  high while in RUN
done  out  1  high while in DONE (WRAP=0 only)
wrap_pulse  out  1  one-cycle pulse when count wraps LIMIT -> 000

Behaviour:
Reset:
- reset sampled high on a rising edge sets: state IDLE, count 12'h000, prescaler 0, running 0, done 0, wrap_pulse 0.
- Applies mid-operation from any state and overrides all commands.

States: IDLE, RUN, DONE.
- IDLE: count held. start -> RUN. step performs one increment.
- RUN: prescaler advances each cycle.
  - At TICK_DIV-1 the prescaler returns to 0 and an internal tick fires.
  - stop -> IDLE; prescaler cleared to 0, count held.
- DONE: count held at LIMIT. start and step ignored. Only clear or reset exits.

Command priority, when commands coincide in one cycle: clear > stop > start > step.
- clear, any state: count 000, prescaler 0, -> IDLE, done 0.
- start while already in RUN: no effect. Prescaler is not restarted.
- step in RUN or DONE: ignored.
- start and step together in IDLE: start wins; no extra increment.

Increment rule (tick in RUN, or accepted step in IDLE):
- If count == LIMIT:
  - WRAP=1: count <= 000, wrap_pulse = 1 for the next cycle, state unchanged.
  - WRAP=0: count held, state <= DONE.
- Else, decimal increment with ripple carry:
  - Ones digit 9 -> 0 with carry into tens; likewise tens into hundreds.
  - Hundreds digit 9 with carry -> 0 (only reachable when LIMIT = 999).
  - Non-carry digits unchanged.
- count never holds a nibble greater than 9.

Latency:
- count, running, done and wrap_pulse are registered.
- A command or tick in cycle N is visible at the outputs in cycle N+1.
- The first RUN increment is visible exactly TICK_DIV cycles after the cycle in which start is sampled.
- Entering RUN starts the prescaler from 0. Resume after stop restarts the full period; partial periods are discarded.

Flag timing:
- running = (state == RUN).
- done = (state == DONE).
- wrap_pulse is never high for 2 consecutive cycles; WRAP=0 never asserts it.

LIMIT = 000: every increment attempt sees count == LIMIT.
- WRAP=1: count stays 000, wrap_pulse on each increment.
- WRAP=0: the first increment enters DONE.

Prescaler width: clog2(TICK_DIV). It is held at 0 outside RUN.

Test Plan:
1. Reset then start, TICK_DIV=4, LIMIT=999 -> first count 001 appears 4 cycles after start. Counting 009 -> 010 -> ... 099 -> 100; running=1 throughout.
2. Counting at 998, WRAP=1 -> 999 then 000. wrap_pulse high for exactly 1 cycle, aligned with count=000; running stays 1.
3. LIMIT=12'h025, WRAP=0, run from 000 -> halts at 025 with done=1, running=0. start/step ignored. clear -> 000, IDLE, done=0.
4. IDLE at 019, pulse step 3 times -> 020, 021, 022. step during RUN -> no change. start+step same cycle -> RUN, no extra increment.
5. RUN with prescaler at 2 of 4, assert stop -> count held. Restart -> next increment 4 cycles after start. start+stop same cycle from IDLE -> stays IDLE.
6. reset mid-RUN at count 357, and clear+start together -> both return count 000 in IDLE, running=0, done=0, wrap_pulse=0.
